// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR tap-window front end.
package fir_pkg;
  localparam int DATA_W = 8;
  localparam int TAPS   = 16;
  localparam int WIN_W  = DATA_W * TAPS;
  localparam int FCNT_W = $clog2(TAPS + 1);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/fir_tap_shreg.sv
// Sample-wide shift register: slot 0 sits in the LSBs, each load pushes toward the MSBs.
module fir_tap_shreg
  import fir_pkg::*;
#(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int TAPS   = fir_pkg::TAPS
) (
  input  logic                   clk,
  input  logic                   i_clr,
  input  logic                   i_load,
  input  logic [DATA_W-1:0]      i_din,
  output logic [DATA_W*TAPS-1:0] o_q
);
  logic [DATA_W*TAPS-1:0] r_q_p0;

  always_ff @(posedge clk) begin
    if (i_clr)
      r_q_p0 <= '0;
    else if (i_load)
      r_q_p0 <= {r_q_p0[DATA_W*TAPS-DATA_W-1:0], i_din};
  end

  assign o_q = r_q_p0;
endmodule

// File: rtl/fir_tap_window_8b_16tap.sv
// 16-sample sliding window with valid/ready handshake in front of the FIR MAC.
// Build option FIR_TAP_WINDOW_ZERO_PREFILL_EN: start full of zeros in RUN instead of filling.
module fir_tap_window_8b_16tap
  import fir_pkg::*;
#(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int TAPS   = fir_pkg::TAPS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W*TAPS-1:0]     m_window,
  output logic [$clog2(TAPS+1)-1:0]  fill_count
);
  localparam int CNT_W = $clog2(TAPS + 1);

`ifdef FIR_TAP_WINDOW_ZERO_PREFILL_EN
  localparam state_t           INIT_STATE = RUN;
  localparam logic [CNT_W-1:0] INIT_CNT   = CNT_W'(TAPS);
`else
  localparam state_t           INIT_STATE = FILL;
  localparam logic [CNT_W-1:0] INIT_CNT   = '0;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_vld_p0;
  logic             w_clr;
  logic             w_accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(TAPS)) ? c : c + 1'b1;
  endfunction

  assign s_ready  = !r_vld_p0 || m_ready;
  assign w_clr    = rst || flush;
  assign w_accept = s_valid && s_ready && !w_clr;

  // The accept that completes the window moves FILL to RUN and already emits it.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept && (r_state == FILL) && (r_cnt == CNT_W'(TAPS - 1)))
      w_state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (w_clr)
      r_state <= INIT_STATE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_clr)
      r_cnt <= INIT_CNT;
    else if (w_accept)
      r_cnt <= sat_inc(r_cnt);
  end

  // Output stage p0: single register, no skid buffer.
  always_ff @(posedge clk) begin
    if (w_clr)
      r_vld_p0 <= 1'b0;
    else if (w_accept)
      r_vld_p0 <= (w_state_nxt == RUN);
    else if (m_ready)
      r_vld_p0 <= 1'b0;
  end

  fir_tap_shreg #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_shreg (
    .clk    (clk),
    .i_clr  (w_clr),
    .i_load (w_accept),
    .i_din  (s_data),
    .o_q    (m_window)
  );

  assign m_valid    = r_vld_p0;
  assign fill_count = r_cnt;
endmodule
